// File: rtl/exmem_wb_stage.sv
// EXMEM->WB pipeline register and writeback stage: latches the EXMEM result, drives the
// register-file write port and forwarding bus, registers EXMEM operand-forward flags, counts retires/bubbles.
module exmem_wb_stage #(
  parameter int DW = 64,
  parameter int RW = 5,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:DW-1] EXMEM_ALU_out,
  input  logic [0:DW-1] dmem_data_out,
  input  logic [RW-1:0] EXMEM_rD,
  input  logic [2:0]    EXMEM_ppp,
  input  logic          EXMEM_wrEn,
  input  logic          EXMEM_valid,
  input  logic          EXMEM_rD_data_select,
  input  logic          EXMEM_stall,
  input  logic [RW-1:0] ID_rA,
  input  logic [RW-1:0] ID_rB,
  input  logic          ID_advance,
  output logic [0:DW-1] WB_data,
  output logic [RW-1:0] WB_rD,
  output logic [2:0]    WB_ppp,
  output logic          WB_wrEn,
  output logic          WB_valid,
  output logic          EXMEM_forward_rA,
  output logic          EXMEM_forward_rB,
  output logic [CW-1:0] retire_count,
  output logic [CW-1:0] bubble_count
);

  function automatic logic [0:DW-1] wb_select(input logic          sel,
                                              input logic [0:DW-1] alu,
                                              input logic [0:DW-1] mem);
    return sel ? mem : alu;
  endfunction

  // Register 0 is deliberately not special-cased: a match forwards like any other register.
  function automatic logic fwd_match(input logic          wr,
                                     input logic          vld,
                                     input logic [RW-1:0] rd,
                                     input logic [RW-1:0] rs);
    return wr & vld & (rd == rs);
  endfunction

  logic          vld_p0;
  logic          wren_p0;
  logic [0:DW-1] data_p0;
  logic          fwd_a_p0;
  logic          fwd_b_p0;

  logic [0:DW-1] data_p1;
  logic [RW-1:0] rd_p1;
  logic [2:0]    ppp_p1;
  logic          vld_p1;
  logic          wren_p1;
  logic          fwd_a_p1;
  logic          fwd_b_p1;
  logic [CW-1:0] retire_p1;
  logic [CW-1:0] bubble_p1;

  // Stage p0: EXMEM side. A stalled instruction never reaches WB as valid, so the RF is written once.
  always_comb begin
    vld_p0   = EXMEM_valid & ~EXMEM_stall;
    wren_p0  = vld_p0 & EXMEM_wrEn;
    data_p0  = wb_select(EXMEM_rD_data_select, EXMEM_ALU_out, dmem_data_out);
    fwd_a_p0 = ID_advance & fwd_match(EXMEM_wrEn, EXMEM_valid, EXMEM_rD, ID_rA);
    fwd_b_p0 = ID_advance & fwd_match(EXMEM_wrEn, EXMEM_valid, EXMEM_rD, ID_rB);
  end

  // Stage p1: WB register. Data/rD/ppp and the forward flags hold across a stall so the bus stays
  // coherent for the instruction held in EXMEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1   <= '0;
      rd_p1     <= '0;
      ppp_p1    <= '0;
      vld_p1    <= 1'b0;
      wren_p1   <= 1'b0;
      fwd_a_p1  <= 1'b0;
      fwd_b_p1  <= 1'b0;
      retire_p1 <= '0;
      bubble_p1 <= '0;
    end else begin
      if (!EXMEM_stall) begin
        data_p1  <= data_p0;
        rd_p1    <= EXMEM_rD;
        ppp_p1   <= EXMEM_ppp;
        fwd_a_p1 <= fwd_a_p0;
        fwd_b_p1 <= fwd_b_p0;
      end
      vld_p1  <= vld_p0;
      wren_p1 <= wren_p0;
      // Counters track the WB_valid value being loaded, so they agree with WB_valid in the same cycle.
      if (vld_p0) retire_p1 <= retire_p1 + CW'(1);
      else        bubble_p1 <= bubble_p1 + CW'(1);
    end
  end

  assign WB_data          = data_p1;
  assign WB_rD            = rd_p1;
  assign WB_ppp           = ppp_p1;
  assign WB_wrEn          = wren_p1;
  assign WB_valid         = vld_p1;
  assign EXMEM_forward_rA = fwd_a_p1;
  assign EXMEM_forward_rB = fwd_b_p1;
  assign retire_count     = retire_p1;
  assign bubble_count     = bubble_p1;

endmodule

// File: tb/tb_exmem_wb_stage.sv
// Directed bench for exmem_wb_stage: linear steps with hand-computed expectations checked by immediate assertions.
module tb_exmem_wb_stage;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:63]   EXMEM_ALU_out, dmem_data_out, WB_data;
  logic [4:0]    EXMEM_rD, ID_rA, ID_rB, WB_rD;
  logic [2:0]    EXMEM_ppp, WB_ppp;
  logic          EXMEM_wrEn, EXMEM_valid, EXMEM_rD_data_select, EXMEM_stall, ID_advance;
  logic          WB_wrEn, WB_valid, EXMEM_forward_rA, EXMEM_forward_rB;
  logic [31:0]   retire_count, bubble_count;

  int total = 0;
  int bad   = 0;

  exmem_wb_stage #(.DW(64), .RW(5), .CW(32)) dut (
    .clk(clk), .reset(reset),
    .EXMEM_ALU_out(EXMEM_ALU_out), .dmem_data_out(dmem_data_out),
    .EXMEM_rD(EXMEM_rD), .EXMEM_ppp(EXMEM_ppp), .EXMEM_wrEn(EXMEM_wrEn),
    .EXMEM_valid(EXMEM_valid), .EXMEM_rD_data_select(EXMEM_rD_data_select),
    .EXMEM_stall(EXMEM_stall), .ID_rA(ID_rA), .ID_rB(ID_rB), .ID_advance(ID_advance),
    .WB_data(WB_data), .WB_rD(WB_rD), .WB_ppp(WB_ppp), .WB_wrEn(WB_wrEn),
    .WB_valid(WB_valid), .EXMEM_forward_rA(EXMEM_forward_rA),
    .EXMEM_forward_rB(EXMEM_forward_rB), .retire_count(retire_count),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".data"},   WB_data, 64'h0);
    check({tag, ".rD"},     64'(WB_rD), 64'h0);
    check({tag, ".ppp"},    64'(WB_ppp), 64'h0);
    check({tag, ".wrEn"},   64'(WB_wrEn), 64'h0);
    check({tag, ".valid"},  64'(WB_valid), 64'h0);
    check({tag, ".fwdA"},   64'(EXMEM_forward_rA), 64'h0);
    check({tag, ".fwdB"},   64'(EXMEM_forward_rB), 64'h0);
    check({tag, ".retire"}, 64'(retire_count), 64'h0);
    check({tag, ".bubble"}, 64'(bubble_count), 64'h0);
  endtask

  initial begin
    reset = 1'b1;
    EXMEM_ALU_out = '0; dmem_data_out = '0; EXMEM_rD = '0; EXMEM_ppp = '0;
    EXMEM_wrEn = 1'b0; EXMEM_valid = 1'b0; EXMEM_rD_data_select = 1'b0;
    EXMEM_stall = 1'b0; ID_rA = '0; ID_rB = '0; ID_advance = 1'b0;
    step();
    step();
    check_all_zero("reset");

    // 1: ALU op retires one cycle later
    reset = 1'b0;
    EXMEM_ALU_out = 64'h0123_4567_89AB_CDEF; EXMEM_rD = 5'd7;
    EXMEM_wrEn = 1'b1; EXMEM_valid = 1'b1;
    step();
    check("alu.data",   WB_data, 64'h0123_4567_89AB_CDEF);
    check("alu.rD",     64'(WB_rD), 64'd7);
    check("alu.wrEn",   64'(WB_wrEn), 64'd1);
    check("alu.valid",  64'(WB_valid), 64'd1);
    check("alu.retire", 64'(retire_count), 64'd1);
    check("alu.bubble", 64'(bubble_count), 64'd0);

    // 2: load to r3, first cycle stalls
    EXMEM_ALU_out = 64'h1111_2222_3333_4444; EXMEM_rD = 5'd3; EXMEM_stall = 1'b1;
    step();
    check("ld1.wrEn",   64'(WB_wrEn), 64'd0);
    check("ld1.valid",  64'(WB_valid), 64'd0);
    check("ld1.data",   WB_data, 64'h0123_4567_89AB_CDEF);
    check("ld1.rD",     64'(WB_rD), 64'd7);
    check("ld1.bubble", 64'(bubble_count), 64'd1);
    EXMEM_stall = 1'b0; EXMEM_rD_data_select = 1'b1; dmem_data_out = 64'hDEAD_BEEF_0000_0001;
    step();
    check("ld2.data",   WB_data, 64'hDEAD_BEEF_0000_0001);
    check("ld2.wrEn",   64'(WB_wrEn), 64'd1);
    check("ld2.rD",     64'(WB_rD), 64'd3);
    check("ld2.retire", 64'(retire_count), 64'd2);

    // 3: forward flags, then a stall holds them
    EXMEM_rD_data_select = 1'b0; EXMEM_ALU_out = 64'h0000_0000_0000_00A5; EXMEM_rD = 5'd5;
    ID_rA = 5'd5; ID_rB = 5'd6; ID_advance = 1'b1;
    step();
    check("fwd.A",      64'(EXMEM_forward_rA), 64'd1);
    check("fwd.B",      64'(EXMEM_forward_rB), 64'd0);
    check("fwd.data",   WB_data, 64'hA5);
    check("fwd.retire", 64'(retire_count), 64'd3);
    EXMEM_stall = 1'b1; EXMEM_ALU_out = 64'hFF; ID_rA = 5'd6; ID_rB = 5'd5;
    step();
    check("hold.A",      64'(EXMEM_forward_rA), 64'd1);
    check("hold.B",      64'(EXMEM_forward_rB), 64'd0);
    check("hold.data",   WB_data, 64'hA5);
    check("hold.valid",  64'(WB_valid), 64'd0);
    check("hold.bubble", 64'(bubble_count), 64'd2);
    EXMEM_stall = 1'b0; ID_advance = 1'b0;
    step();
    check("noadv.A",      64'(EXMEM_forward_rA), 64'd0);
    check("noadv.B",      64'(EXMEM_forward_rB), 64'd0);
    check("noadv.data",   WB_data, 64'hFF);
    check("noadv.retire", 64'(retire_count), 64'd4);

    // 4: invalid instruction with wrEn set and rD match
    EXMEM_valid = 1'b0; EXMEM_rD = 5'd9; ID_rA = 5'd9; ID_advance = 1'b1; EXMEM_ALU_out = 64'h77;
    step();
    check("nop.wrEn",   64'(WB_wrEn), 64'd0);
    check("nop.valid",  64'(WB_valid), 64'd0);
    check("nop.fwdA",   64'(EXMEM_forward_rA), 64'd0);
    check("nop.bubble", 64'(bubble_count), 64'd3);
    check("nop.retire", 64'(retire_count), 64'd4);

    // 5: partial write select passes through; r0 forwards normally
    EXMEM_valid = 1'b1; EXMEM_rD = 5'd0; ID_rA = 5'd1; ID_rB = 5'd0;
    EXMEM_ppp = 3'b011; EXMEM_ALU_out = 64'hCAFE_0000_F00D_0001;
    step();
    check("ppp.ppp",    64'(WB_ppp), 64'd3);
    check("ppp.data",   WB_data, 64'hCAFE_0000_F00D_0001);
    check("ppp.fwdA",   64'(EXMEM_forward_rA), 64'd0);
    check("ppp.fwdB",   64'(EXMEM_forward_rB), 64'd1);
    check("ppp.retire", 64'(retire_count), 64'd5);

    // 6: reset asserted mid-stall
    EXMEM_stall = 1'b1; EXMEM_ppp = 3'b000;
    step();
    check("pre.bubble", 64'(bubble_count), 64'd4);
    check("pre.fwdB",   64'(EXMEM_forward_rB), 64'd1);
    reset = 1'b1;
    step();
    check_all_zero("midrst");
    reset = 1'b0; EXMEM_stall = 1'b0; ID_advance = 1'b0; EXMEM_rD = 5'd12;
    EXMEM_ALU_out = 64'h42;
    step();
    check("post.valid",  64'(WB_valid), 64'd1);
    check("post.wrEn",   64'(WB_wrEn), 64'd1);
    check("post.data",   WB_data, 64'h42);
    check("post.rD",     64'(WB_rD), 64'd12);
    check("post.retire", 64'(retire_count), 64'd1);
    check("post.bubble", 64'(bubble_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
